mu0_run_ctrl: RTL and testbench

- Parametrised run-control and breakpoint unit between the debug host interface and the MU0-class CPU.
- Generates a per-cycle CPU clock enable and a CPU reset.
- Supports NUM_BP hardware address breakpoints, N-instruction single-stepping and a saturating executed-cycle counter.
- Generalises the single breakpoint, free-run/step arrangement to arbitrary address width, breakpoint count and step depth.

---
 rtl/mu0_run_ctrl_if.sv | 39 +++
 rtl/mu0_run_ctrl.sv | 137 +++++++++++++
 tb/tb_mu0_run_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mu0_run_ctrl_if.sv
// Host/CPU-side bundle of the MU0 run-control unit: debug command channel,
// breakpoint programming port, CPU fetch observation and run-control outputs.
interface mu0_run_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_arg;
  logic              cmd_ready;
  logic              bp_wr;
  logic [IDX_W-1:0]  bp_idx;
  logic [ADDR_W-1:0] bp_addr;
  logic              bp_en;
  logic              fetch;
  logic [ADDR_W-1:0] pc;
  logic              cpu_clk_en;
  logic              cpu_reset;
  logic              halted;
  logic              bp_hit;
  logic [IDX_W-1:0]  bp_hit_idx;
  logic [CNT_W-1:0]  step_left;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, bp_wr, bp_idx, bp_addr, bp_en, fetch, pc,
    input  cmd_ready, cpu_clk_en, cpu_reset, halted, bp_hit, bp_hit_idx,
           step_left, cycle_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, bp_wr, bp_idx, bp_addr, bp_en, fetch, pc,
    output cmd_ready, cpu_clk_en, cpu_reset, halted, bp_hit, bp_hit_idx,
           step_left, cycle_count
  );
endinterface

// File: rtl/mu0_run_ctrl.sv
// Run-control and breakpoint unit for an MU0-class CPU: gates the CPU clock
// enable, sequences CPU reset, and handles breakpoints, stepping and cycle count.
module mu0_run_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int NUM_BP     = 4,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  mu0_run_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

  // Any other opcode, including 0, is a no-op.
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_RESET  = 3'd4;
  localparam logic [2:0] OP_CLRHIT = 3'd5;
  localparam logic [2:0] OP_CLRCNT = 3'd6;

  typedef enum logic [1:0] {RESETTING, HALTED, RUNNING, STEPPING} state_t;

  state_t            state, state_nxt;
  logic [RC_W-1:0]   rst_cnt;
  logic [ADDR_W-1:0] slot_addr [NUM_BP];
  logic [NUM_BP-1:0] slot_en;
  logic              skip;
  logic [CNT_W-1:0]  step_left;
  logic [CNT_W-1:0]  cycle_count;
  logic              bp_hit;
  logic [IDX_W-1:0]  bp_hit_idx;

  logic              accept, run, bp_match, bp_stop, step_stop, stop, clk_en, advance;
  logic [IDX_W-1:0]  match_idx;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign run    = (state == RUNNING) || (state == STEPPING);

  // Scan from the top so the lowest matching slot wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bp_match  = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_en[i] && (slot_addr[i] == bus.pc)) begin
        bp_match  = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // Stops only matter while the CPU is being clocked; a halted CPU parked on a
  // breakpoint address must not keep re-asserting the hit.
  assign bp_stop   = run && bus.fetch && bp_match && !skip;
  assign step_stop = (state == STEPPING) && bus.fetch && (step_left == '0);
  assign stop      = bp_stop || step_stop;
  assign clk_en    = run && !stop;
  assign advance   = clk_en && bus.fetch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESETTING;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESETTING: if (rst_cnt == '0) state_nxt = HALTED;
      HALTED: begin
        if (accept && bus.cmd_op == OP_RUN)  state_nxt = RUNNING;
        if (accept && bus.cmd_op == OP_STEP) state_nxt = STEPPING;
      end
      RUNNING, STEPPING: begin
        if (stop || (accept && bus.cmd_op == OP_HALT)) state_nxt = HALTED;
      end
      default: state_nxt = RESETTING;
    endcase
    if (accept && bus.cmd_op == OP_RESET) state_nxt = RESETTING;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the breakpoint slots are architecturally visible after reset, so
      // this small register file is reset along with the control state.
      for (int i = 0; i < NUM_BP; i++) slot_addr[i] <= '0;
      slot_en     <= '0;
      rst_cnt     <= RC_LOAD;
      skip        <= 1'b0;
      step_left   <= '0;
      cycle_count <= '0;
      bp_hit      <= 1'b0;
      bp_hit_idx  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept && bus.cmd_op == OP_RESET)         rst_cnt <= RC_LOAD;
      else if (state == RESETTING && rst_cnt != '0) rst_cnt <= rst_cnt - RC_W'(1);

      if (accept && state == HALTED && (bus.cmd_op == OP_RUN || bus.cmd_op == OP_STEP))
        skip <= 1'b1;
      else if (advance)
        skip <= 1'b0;

      if (accept && state == HALTED && bus.cmd_op == OP_STEP)
        step_left <= (bus.cmd_arg == '0) ? CNT_W'(1) : bus.cmd_arg;
      else if (advance && state == STEPPING)
        step_left <= step_left - CNT_W'(1);

      if (bp_stop) begin
        bp_hit     <= 1'b1;
        bp_hit_idx <= match_idx;
      end else if (accept && bus.cmd_op == OP_CLRHIT) begin
        bp_hit     <= 1'b0;
      end

      if (accept && bus.cmd_op == OP_CLRCNT)  cycle_count <= '0;
      else if (clk_en && cycle_count != '1)   cycle_count <= cycle_count + CNT_W'(1);

      if (bus.bp_wr && (32'(bus.bp_idx) < 32'(NUM_BP))) begin
        slot_addr[bus.bp_idx] <= bus.bp_addr;
        slot_en[bus.bp_idx]   <= bus.bp_en;
      end
    end
  end

  assign bus.cmd_ready   = (state != RESETTING);
  assign bus.cpu_clk_en  = clk_en;
  assign bus.cpu_reset   = (state == RESETTING);
  assign bus.halted      = (state == HALTED);
  assign bus.bp_hit      = bp_hit;
  assign bus.bp_hit_idx  = bp_hit_idx;
  assign bus.step_left   = step_left;
  assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_mu0_run_ctrl.sv
// Directed bench for mu0_run_ctrl: a sequential-fetch CPU model, a table of
// command/expectation records and hand-written multi-cycle corner sequences.
module tb_mu0_run_ctrl;
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_RESET  = 3'd4;
  localparam logic [2:0] OP_CLRHIT = 3'd5;
  localparam logic [2:0] OP_CLRCNT = 3'd6;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] arg;
    int          wait_cyc;
    logic        halted;
    logic        hit;
    logic [1:0]  idx;
    logic [15:0] left;
    logic [11:0] pc;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl [10];

  always #5 clk = ~clk;

  mu0_run_ctrl_if #(.ADDR_W(12), .NUM_BP(4), .CNT_W(16)) d ();
  mu0_run_ctrl_if #(.ADDR_W(12), .NUM_BP(4), .CNT_W(4))  s ();

  mu0_run_ctrl #(.ADDR_W(12), .NUM_BP(4), .CNT_W(16), .RST_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .bus(d.slave)
  );
  mu0_run_ctrl #(.ADDR_W(12), .NUM_BP(4), .CNT_W(4), .RST_CYCLES(4)) u_sat (
    .clk(clk), .rst(rst), .bus(s.slave)
  );

  // CPU model: every cycle is a fetch; pc advances on each enabled cycle.
  always @(posedge clk) begin
    if (d.cpu_reset)       d.pc <= 12'h000;
    else if (d.cpu_clk_en) d.pc <= d.pc + 12'd1;
    if (s.cpu_reset)       s.pc <= 12'h000;
    else if (s.cpu_clk_en) s.pc <= s.pc + 12'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_cmd(input logic [2:0] op, input logic [15:0] arg);
    @(posedge clk); #1;
    d.cmd_valid = 1'b1; d.cmd_op = op; d.cmd_arg = arg;
    @(posedge clk); #1;
    d.cmd_valid = 1'b0; d.cmd_op = OP_NOP; d.cmd_arg = '0;
  endtask

  task automatic bp_write(input logic [1:0] idx, input logic [11:0] addr, input logic en);
    @(posedge clk); #1;
    d.bp_wr = 1'b1; d.bp_idx = idx; d.bp_addr = addr; d.bp_en = en;
    @(posedge clk); #1;
    d.bp_wr = 1'b0;
  endtask

  // Counts consecutive sampled cycles with cpu_reset high, starting now.
  task automatic reset_window(input string tag, output int n);
    n = 0;
    @(negedge clk);
    check({tag, " ready low"}, 32'(d.cmd_ready), 32'd0);
    check({tag, " clk_en low"}, 32'(d.cpu_clk_en), 32'd0);
    if (d.cpu_reset) n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d.cpu_reset) n++;
      else break;
    end
  endtask

  initial begin
    int  n;
    bit  found;

    d.cmd_valid = 1'b0; d.cmd_op = OP_NOP; d.cmd_arg = '0;
    d.bp_wr = 1'b0; d.bp_idx = '0; d.bp_addr = '0; d.bp_en = 1'b0; d.fetch = 1'b1;
    s.cmd_valid = 1'b0; s.cmd_op = OP_NOP; s.cmd_arg = '0;
    s.bp_wr = 1'b0; s.bp_idx = '0; s.bp_addr = '0; s.bp_en = 1'b0; s.fetch = 1'b1;

    //        op         arg    wait halt hit idx  left   pc       cnt
    tbl[0] = '{OP_RUN,    16'd0, 30, 1'b1, 1'b1, 2'd2, 16'd0, 12'h010, 16'd16};
    tbl[1] = '{OP_RUN,    16'd0,  5, 1'b0, 1'b1, 2'd2, 16'd0, 12'h015, 16'd21};
    tbl[2] = '{OP_HALT,   16'd0,  2, 1'b1, 1'b1, 2'd2, 16'd0, 12'h017, 16'd23};
    tbl[3] = '{OP_STEP,   16'd3,  6, 1'b1, 1'b1, 2'd2, 16'd0, 12'h01A, 16'd26};
    tbl[4] = '{OP_STEP,   16'd0,  4, 1'b1, 1'b1, 2'd2, 16'd0, 12'h01B, 16'd27};
    tbl[5] = '{OP_CLRHIT, 16'd0,  1, 1'b1, 1'b0, 2'd2, 16'd0, 12'h01B, 16'd27};
    tbl[6] = '{OP_STEP,   16'd5,  2, 1'b0, 1'b0, 2'd2, 16'd3, 12'h01D, 16'd29};
    tbl[7] = '{OP_HALT,   16'd0,  1, 1'b1, 1'b0, 2'd2, 16'd1, 12'h01F, 16'd31};
    tbl[8] = '{OP_CLRCNT, 16'd0,  1, 1'b1, 1'b0, 2'd2, 16'd1, 12'h01F, 16'd0};
    tbl[9] = '{OP_NOP,    16'd0,  2, 1'b1, 1'b0, 2'd2, 16'd1, 12'h01F, 16'd0};

    // Power-on reset: cpu_reset held exactly four cycles after rst drops.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    reset_window("por", n);
    check("por reset cycles", 32'(n), 32'd4);
    check("por halted", 32'(d.halted), 32'd1);
    check("por clk_en", 32'(d.cpu_clk_en), 32'd0);
    check("por ready", 32'(d.cmd_ready), 32'd1);
    check("por cycle_count", 32'(d.cycle_count), 32'd0);
    check("por bp_hit", 32'(d.bp_hit), 32'd0);
    check("por step_left", 32'(d.step_left), 32'd0);
    check("por sat cycle_count", 32'(s.cycle_count), 32'd0);

    bp_write(2'd2, 12'h010, 1'b1);

    for (int i = 0; i < 10; i++) begin
      apply_cmd(tbl[i].op, tbl[i].arg);
      repeat (tbl[i].wait_cyc) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d halted", i), 32'(d.halted), 32'(tbl[i].halted));
      check($sformatf("v%0d clk_en", i), 32'(d.cpu_clk_en), 32'(!tbl[i].halted));
      check($sformatf("v%0d bp_hit", i), 32'(d.bp_hit), 32'(tbl[i].hit));
      check($sformatf("v%0d bp_hit_idx", i), 32'(d.bp_hit_idx), 32'(tbl[i].idx));
      check($sformatf("v%0d step_left", i), 32'(d.step_left), 32'(tbl[i].left));
      check($sformatf("v%0d pc", i), 32'(d.pc), 32'(tbl[i].pc));
      check($sformatf("v%0d cycle_count", i), 32'(d.cycle_count), 32'(tbl[i].cnt));
    end

    // Two slots on the same address plus a HALT in the hit cycle.
    bp_write(2'd0, 12'h020, 1'b1);
    bp_write(2'd3, 12'h020, 1'b1);
    apply_cmd(OP_RUN, 16'd0);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (d.pc == 12'h020) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("conc reached 0x020", 32'(found), 32'd1);
    d.cmd_valid = 1'b1; d.cmd_op = OP_HALT;
    @(posedge clk); #1;
    d.cmd_valid = 1'b0; d.cmd_op = OP_NOP;
    @(negedge clk);
    check("conc halted", 32'(d.halted), 32'd1);
    check("conc bp_hit", 32'(d.bp_hit), 32'd1);
    check("conc bp_hit_idx", 32'(d.bp_hit_idx), 32'd0);
    check("conc pc", 32'(d.pc), 32'h020);
    check("conc cycle_count", 32'(d.cycle_count), 32'd1);
    apply_cmd(OP_CLRHIT, 16'd0);
    @(negedge clk);
    check("clrhit bp_hit", 32'(d.bp_hit), 32'd0);
    check("clrhit halted", 32'(d.halted), 32'd1);

    // RESET while running; a RUN offered during RESETTING must be ignored.
    apply_cmd(OP_RUN, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrun running", 32'(d.cpu_clk_en), 32'd1);
    apply_cmd(OP_RESET, 16'd0);
    d.cmd_valid = 1'b1; d.cmd_op = OP_RUN;
    fork
      begin
        @(posedge clk); #1;
        d.cmd_valid = 1'b0; d.cmd_op = OP_NOP;
      end
    join_none
    reset_window("midrun", n);
    check("midrun reset cycles", 32'(n), 32'd4);
    check("midrun halted", 32'(d.halted), 32'd1);
    check("midrun clk_en", 32'(d.cpu_clk_en), 32'd0);
    check("midrun pc", 32'(d.pc), 32'h000);
    check("midrun bp_hit kept", 32'(d.bp_hit), 32'd0);
    apply_cmd(OP_RUN, 16'd0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("slots kept halted", 32'(d.halted), 32'd1);
    check("slots kept bp_hit", 32'(d.bp_hit), 32'd1);
    check("slots kept idx", 32'(d.bp_hit_idx), 32'd2);
    check("slots kept pc", 32'(d.pc), 32'h010);

    // 4-bit cycle counter saturates, then CLRCNT wins over an enabled cycle.
    @(posedge clk); #1;
    s.cmd_valid = 1'b1; s.cmd_op = OP_RUN;
    @(posedge clk); #1;
    s.cmd_valid = 1'b0; s.cmd_op = OP_NOP;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sat running", 32'(s.halted), 32'd0);
    check("sat cycle_count", 32'(s.cycle_count), 32'd15);
    @(posedge clk); #1;
    s.cmd_valid = 1'b1; s.cmd_op = OP_CLRCNT;
    @(posedge clk); #1;
    s.cmd_valid = 1'b0; s.cmd_op = OP_NOP;
    @(negedge clk);
    check("sat clrcnt", 32'(s.cycle_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
